// File: rtl/p1v_reset_pkg.sv
// Shared types for the P1V reset conditioner: FSM states and reset-cause codes.
package p1v_reset_pkg;

   typedef enum logic [1:0] {
      S_POR     = 2'd0,
      S_RESET   = 2'd1,
      S_STRETCH = 2'd2,
      S_RUN     = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_SW   = 2'b01;
   localparam logic [1:0] CAUSE_PLUG = 2'b10;
   localparam logic [1:0] CAUSE_BOTH = 2'b11;

endpackage

// File: rtl/p1v_input_filter.sv
// Synchroniser plus stability filter for one asynchronous reset source.
// The output follows the synchronised input only after CYCLES consecutive mismatching cycles.
module p1v_input_filter #(
   parameter int   STAGES    = 2,
   parameter int   CYCLES    = 16,
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic filt_o
);

   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [STAGES-1:0] sync_q;
   logic [CW-1:0]     cnt_q;
   logic              filt_q;
   logic              synced;

   assign synced = sync_q[STAGES-1];
   assign filt_o = filt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {STAGES{RESET_VAL}};
         filt_q <= RESET_VAL;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_i};
         // The counter tops out at LAST, where the output flips and the count restarts.
         if (synced == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == LAST) begin
            filt_q <= synced;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/p1v_reset_ctrl.sv
// Conditions switch and Prop-plug resets into the P1V core's active-low inp_resn.
// Optional reset_count output is built when P1V_RESET_COUNT_EN is defined.
module p1v_reset_ctrl
   import p1v_reset_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int DEBOUNCE_CYCLES    = 1600000,
   parameter int PLUG_FILTER_CYCLES = 16,
   parameter int MIN_RESET_CYCLES   = 160000,
   parameter int POR_CYCLES         = 1600000
) (
   input  logic       clock_160,
   input  logic       reset,
   input  logic       tact_n,
   input  logic       plug_resn,
   output logic       inp_resn,
   output logic       in_reset,
   output logic [1:0] reset_cause
`ifdef P1V_RESET_COUNT_EN
   ,
   output logic [7:0] reset_count
`endif
);

   localparam int CNT_MAX = (POR_CYCLES > MIN_RESET_CYCLES) ? POR_CYCLES : MIN_RESET_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_RESET_CYCLES - 1);

   logic             sw_filt;
   logic             plug_filt;
   logic             sw_pressed;
   logic             plug_active;
   logic             req;
   logic [1:0]       cause_d;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             inp_resn_q;
   logic             in_reset_q;
   logic [1:0]       cause_q;

   p1v_input_filter #(
      .STAGES    (SYNC_STAGES),
      .CYCLES    (DEBOUNCE_CYCLES),
      .RESET_VAL (1'b1)
   ) u_sw_filter (
      .clk_i   (clock_160),
      .rst_i   (reset),
      .async_i (tact_n),
      .filt_o  (sw_filt)
   );

   p1v_input_filter #(
      .STAGES    (SYNC_STAGES),
      .CYCLES    (PLUG_FILTER_CYCLES),
      .RESET_VAL (1'b1)
   ) u_plug_filter (
      .clk_i   (clock_160),
      .rst_i   (reset),
      .async_i (plug_resn),
      .filt_o  (plug_filt)
   );

   assign sw_pressed  = ~sw_filt;
   assign plug_active = ~plug_filt;
   assign req         = sw_pressed | plug_active;
   assign cause_d     = {plug_active, sw_pressed};

   assign inp_resn    = inp_resn_q;
   assign in_reset    = in_reset_q;
   assign reset_cause = cause_q;

   always_ff @(posedge clock_160) begin
      if (reset) begin
         state_q    <= S_POR;
         cnt_q      <= '0;
         inp_resn_q <= 1'b0;
         in_reset_q <= 1'b1;
         cause_q    <= CAUSE_POR;
      end else begin
         // Outputs follow the current state, so they trail a state change by one cycle.
         inp_resn_q <= (state_q == S_RUN);
         in_reset_q <= (state_q != S_RUN);
         case (state_q)
            S_POR: begin
               if (cnt_q == POR_LAST) begin
                  cnt_q <= '0;
                  if (req) begin
                     state_q <= S_RESET;
                     cause_q <= cause_d;
                  end else begin
                     state_q <= S_STRETCH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RESET: begin
               cnt_q <= '0;
               if (!req) state_q <= S_STRETCH;
            end
            S_STRETCH: begin
               // A new request wins over a stretch that is just completing.
               if (req) begin
                  state_q <= S_RESET;
                  cnt_q   <= '0;
               end else if (cnt_q == MIN_LAST) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               cnt_q <= '0;
               if (req) begin
                  state_q <= S_RESET;
                  cause_q <= cause_d;
               end
            end
            default: begin
               state_q <= S_POR;
               cnt_q   <= '0;
            end
         endcase
      end
   end

`ifdef P1V_RESET_COUNT_EN
   logic [7:0] rcount_q;

   assign reset_count = rcount_q;

   always_ff @(posedge clock_160) begin
      if (reset) begin
         rcount_q <= '0;
      end else if ((state_q == S_RUN) && req && (rcount_q != 8'hFF)) begin
         rcount_q <= rcount_q + 1'b1;
      end
   end
`endif

endmodule
